// File: rtl/dfr_pkg.sv
// Shared definitions for the DFR sample-batching controller.
//   dfr_state_e    : controller FSM states (IDLE, START, RUN)
//   DFR_DATA_WIDTH : default RX sample width (packed I/Q)
package dfr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } dfr_state_e;

  localparam int DFR_DATA_WIDTH = 32;

endpackage

// File: rtl/dfr_sample_fifo.sv
// Count-based synchronous FIFO with registered read data.
// Ports:
//   clk, reset     : rising-edge clock, async active-high reset
//   wreq, wdata    : write strobe / data (dropped when full)
//   rreq, rdata    : read strobe / data (rdata updates one edge after an accepted read)
//   count          : entries held, $clog2(DEPTH)+1 bits
//   full, empty    : combinational from the registered count
module dfr_sample_fifo
  import dfr_pkg::*;
#(
  parameter int DATA_WIDTH = DFR_DATA_WIDTH,
  parameter int DEPTH      = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wreq,
  input  logic [DATA_WIDTH-1:0]      wdata,
  input  logic                       rreq,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wptr, rptr;
  logic                  wr_ok, rd_ok;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  // Accept decisions use the pre-edge count, so a write while full is
  // dropped even if a read frees a slot on the same edge.
  assign wr_ok = wreq && !full;
  assign rd_ok = rreq && !empty;

  // Storage carries no reset; an empty FIFO never exposes stale entries.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= wdata;
  end

  // Pointers are AW bits wide so power-of-two depth wraps for free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      rdata <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) begin
        rptr  <= rptr + 1'b1;
        rdata <= mem[rptr];
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dfr_fsm_ctrl.sv
// Sample-batching controller in front of the DFR core. Buffers RX samples,
// pulses dfr_start once BATCH_SIZE samples are queued, then counts
// processed samples until the core signals dfr_done.
// Ports:
//   clk, reset                 : rising-edge clock, async active-high reset
//   rx_sample_wreq/wdata       : sample write side
//   rx_sample_fifo_full        : FIFO full
//   rx_sample_fifo_rreq/rdata  : core read side, 1-cycle registered data
//   rx_sample_fifo_rempty      : FIFO empty
//   dfr_start                  : one-cycle launch pulse (START state)
//   dfr_next_sample, dfr_done  : core progress / completion
//   dfr_busy                   : START or RUN
//   processed_count            : samples processed in current/last run
//   overflow                   : sticky, a write was dropped while full
module dfr_fsm_ctrl
  import dfr_pkg::*;
#(
  parameter int DATA_WIDTH = DFR_DATA_WIDTH,
  parameter int FIFO_DEPTH = 16,
  parameter int BATCH_SIZE = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_sample_wreq,
  input  logic [DATA_WIDTH-1:0]         rx_sample_wdata,
  output logic                          rx_sample_fifo_full,
  input  logic                          rx_sample_fifo_rreq,
  output logic [DATA_WIDTH-1:0]         rx_sample_fifo_rdata,
  output logic                          rx_sample_fifo_rempty,
  output logic                          dfr_start,
  input  logic                          dfr_next_sample,
  input  logic                          dfr_done,
  output logic                          dfr_busy,
  output logic [$clog2(FIFO_DEPTH):0]   processed_count,
  output logic                          overflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  dfr_state_e    state, state_nxt;
  logic [CW-1:0] fifo_count;

  dfr_sample_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wreq  (rx_sample_wreq),
    .wdata (rx_sample_wdata),
    .rreq  (rx_sample_fifo_rreq),
    .rdata (rx_sample_fifo_rdata),
    .count (fifo_count),
    .full  (rx_sample_fifo_full),
    .empty (rx_sample_fifo_rempty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    dfr_start = 1'b0;
    dfr_busy  = 1'b0;
    unique case (state)
      IDLE: begin
        if (fifo_count >= CW'(BATCH_SIZE)) state_nxt = START;
      end
      START: begin
        dfr_start = 1'b1;
        dfr_busy  = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        dfr_busy = 1'b1;
        if (dfr_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Cleared on entry to START so the count reads 0 while dfr_start is high;
  // it keeps its final value after the run until the next launch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      processed_count <= '0;
    end else if (state == IDLE && state_nxt == START) begin
      processed_count <= '0;
    end else if (state == RUN && dfr_next_sample &&
                 processed_count != CW'(FIFO_DEPTH)) begin
      processed_count <= processed_count + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   overflow <= 1'b0;
    else if (rx_sample_wreq && rx_sample_fifo_full) overflow <= 1'b1;
  end

endmodule

// File: tb/tb_dfr_fsm_ctrl.sv
// Self-checking bench for dfr_fsm_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked each cycle against a
// queue-based behavioural model.
module tb_dfr_fsm_ctrl;

  localparam int DW = 32;
  localparam int D  = 16;
  localparam int B  = 8;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wreq = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic          full;
  logic          rreq = 1'b0;
  logic [DW-1:0] rdata;
  logic          rempty;
  logic          start;
  logic          nxt = 1'b0;
  logic          done = 1'b0;
  logic          busy;
  logic [CW-1:0] pcount;
  logic          ovf;

  int n_cmp = 0;
  int n_err = 0;

  dfr_fsm_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(D), .BATCH_SIZE(B)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .rx_sample_wreq        (wreq),
    .rx_sample_wdata       (wdata),
    .rx_sample_fifo_full   (full),
    .rx_sample_fifo_rreq   (rreq),
    .rx_sample_fifo_rdata  (rdata),
    .rx_sample_fifo_rempty (rempty),
    .dfr_start             (start),
    .dfr_next_sample       (nxt),
    .dfr_done              (done),
    .dfr_busy              (busy),
    .processed_count       (pcount),
    .overflow              (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The controller is either idle, or "busy" on a run; the first busy cycle
  // is the launch cycle. Decisions use the FIFO occupancy before the edge.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_rdata;
  bit            m_ovf, m_busy, m_start;
  int            m_pc;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      mq.delete();
      m_rdata = '0; m_ovf = 0; m_busy = 0; m_start = 0; m_pc = 0;
    end else begin
      int  sz;
      bit  rd_ok, wr_ok;
      sz = mq.size();
      if (!m_busy) begin
        if (sz >= B) begin m_busy = 1; m_start = 1; m_pc = 0; end
      end else if (m_start) begin
        m_start = 0;
      end else begin
        if (nxt && m_pc < D) m_pc++;
        if (done) m_busy = 0;
      end
      rd_ok = rreq && sz > 0;
      wr_ok = wreq && sz < D;
      if (rd_ok) m_rdata = mq.pop_front();
      if (wr_ok) mq.push_back(wdata);
      if (wreq && !wr_ok) m_ovf = 1;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      chk("rempty", rempty, mq.size() == 0);
      chk("full",   full,   mq.size() == D);
      chk("rdata",  rdata,  m_rdata);
      chk("start",  start,  m_start);
      chk("busy",   busy,   m_busy);
      chk("pcount", pcount, m_pc);
      chk("ovf",    ovf,    m_ovf);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wreq = 0; rreq = 0; nxt = 0; done = 0;
    step(); step();
    reset = 1'b0;
  endtask

  initial begin
    // Reset values
    do_reset();
    chk("rst_rempty", rempty, 1);
    chk("rst_full",   full,   0);
    chk("rst_start",  start,  0);
    chk("rst_busy",   busy,   0);
    chk("rst_ovf",    ovf,    0);
    chk("rst_pcount", pcount, 0);
    chk("rst_rdata",  rdata,  0);

    // Batch trigger: 7 writes do not launch
    for (int i = 1; i <= 7; i++) begin
      wreq = 1; wdata = i; step();
      chk("no_start_7", start, 0);
    end
    wreq = 0; step();
    chk("no_start_7_idle", start, 0);
    wreq = 1; wdata = 8; step();
    wreq = 0;
    chk("start_not_yet", start, 0);
    step();
    chk("start_pulse", start, 1);
    chk("start_busy",  busy,  1);
    chk("start_pc0",   pcount, 0);
    step();
    chk("start_one_cycle", start, 0);
    chk("run_busy", busy, 1);

    // Run: pop 8 with next_sample after each
    for (int i = 1; i <= 8; i++) begin
      rreq = 1; step(); rreq = 0;
      chk("run_rdata", rdata, i);
      nxt = 1; step(); nxt = 0;
    end
    chk("run_rempty", rempty, 1);
    chk("run_pc8", pcount, 8);
    done = 1; step(); done = 0;
    chk("done_busy", busy, 0);
    chk("done_pc_hold", pcount, 8);

    // Overflow: 17 writes, no reads
    for (int i = 1; i <= 17; i++) begin
      wreq = 1; wdata = i; step();
    end
    wreq = 0;
    chk("ovf_full", full, 1);
    chk("ovf_flag", ovf, 1);
    rreq = 1;
    for (int i = 1; i <= 16; i++) begin
      step();
      chk("ovf_contents", rdata, i);
    end
    // Empty read: rdata holds, FIFO stays empty
    step(); rreq = 0;
    chk("empty_rd_rdata", rdata, 32'h10);
    chk("empty_rd_rempty", rempty, 1);
    chk("ovf_sticky", ovf, 1);
    done = 1; step(); done = 0;
    step();

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      wreq  = ($urandom_range(0, 1) == 1);
      wdata = $urandom;
      rreq  = ($urandom_range(0, 9) < 4);
      nxt   = ($urandom_range(0, 1) == 1);
      done  = ($urandom_range(0, 9) == 0);
      step();
    end
    wreq = 0; rreq = 0; nxt = 0; done = 0;
    step();

    // Mid-run reset with 5 samples buffered
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      wreq = 1; wdata = 32'h100 + i; step();
    end
    wreq = 0;
    step(); step();
    chk("mid_in_run_busy", busy, 1);
    chk("mid_in_run_start", start, 0);
    rreq = 1; step(); step(); step(); rreq = 0;
    chk("mid_rdata3", rdata, 32'h103);
    chk("mid_not_empty", rempty, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_rempty", rempty, 1);
    chk("mid_rst_busy",   busy,   0);
    chk("mid_rst_start",  start,  0);
    chk("mid_rst_pc",     pcount, 0);
    chk("mid_rst_rdata",  rdata,  0);
    chk("mid_rst_state",  dut.state, 0);
    step(); step();
    reset = 1'b0;
    step(); step();
    chk("post_rst_rempty", rempty, 1);
    chk("post_rst_busy",   busy,   0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
